// File: rtl/bus4_arbiter.sv
// Round-robin arbiter for the shared 4-bit operand path between two requesters.
// Owns the operand mux select, bounds contended tenures, and registers the transferred nibble.
module bus4_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic [3:0] in1_i,
    input  logic [3:0] in2_i,
    output logic       gnt0_o,
    output logic       gnt1_o,
    output logic       sel_o,
    output logic [3:0] out_o,
    output logic       out_valid_o
);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    localparam logic [4:0] MaxHold = 5'(MAX_HOLD);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] out_q, out_d;
    logic       out_valid_q, out_valid_d;

    logic       xfer;
    logic [4:0] xfer_num;
    logic       hold_done;

    always_comb begin
        xfer      = ((state_q == StGnt0) && req0_i) || ((state_q == StGnt1) && req1_i);
        // Ordinal of the transfer happening this cycle within the current tenure.
        xfer_num  = {1'b0, hold_q} + 5'd1;
        hold_done = (xfer_num >= MaxHold);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req0_i && req1_i) begin
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (req0_i) begin
                    state_d = StGnt0;
                end else if (req1_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!req0_i) begin
                    state_d = req1_i ? StGnt1 : StIdle;
                end else if (req1_i && hold_done) begin
                    state_d = StGnt1;
                end
            end
            StGnt1: begin
                if (!req1_i) begin
                    state_d = req0_i ? StGnt0 : StIdle;
                end else if (req0_i && hold_done) begin
                    state_d = StGnt0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hold_d = hold_q;
        last_d = last_q;
        if (state_d != state_q) begin
            hold_d = 4'h0;
            if (state_d == StGnt0) begin
                last_d = 1'b0;
            end else if (state_d == StGnt1) begin
                last_d = 1'b1;
            end
        end else if (xfer && (hold_q != 4'hF)) begin
            hold_d = hold_q + 4'h1;
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = xfer;
        if (xfer) begin
            out_d = (state_q == StGnt1) ? in2_i : in1_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            hold_q      <= 4'h0;
            out_q       <= 4'h0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign gnt0_o      = (state_q == StGnt0);
    assign gnt1_o      = (state_q == StGnt1);
    assign sel_o       = (state_q == StGnt1);
    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_bus4_arbiter.sv
// Bench for bus4_arbiter: instance 0 uses MAX_HOLD=4, instance 1 uses MAX_HOLD=1.
// Directed scenarios plus randomized traffic checked against a tenure-level model.
module tb_bus4_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req0;
    logic [1:0] req1;
    logic [3:0] in1 [2];
    logic [3:0] in2 [2];
    wire  [1:0] gnt0;
    wire  [1:0] gnt1;
    wire  [1:0] sel;
    wire  [1:0] ov;
    wire  [3:0] dout_a;
    wire  [3:0] dout_b;

    int total = 0;
    int bad   = 0;

    // Model: owner is -1 when idle, else the granted requester; cnt is transfers this tenure.
    int         m_owner [2];
    int         m_cnt   [2];
    int         m_last  [2];
    logic [3:0] m_out   [2];
    logic       m_ov    [2];
    int         maxh    [2];

    bus4_arbiter #(.MAX_HOLD(4)) u_dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .req0_i     (req0[0]),
        .req1_i     (req1[0]),
        .in1_i      (in1[0]),
        .in2_i      (in2[0]),
        .gnt0_o     (gnt0[0]),
        .gnt1_o     (gnt1[0]),
        .sel_o      (sel[0]),
        .out_o      (dout_a),
        .out_valid_o(ov[0])
    );

    bus4_arbiter #(.MAX_HOLD(1)) u_dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .req0_i     (req0[1]),
        .req1_i     (req1[1]),
        .in1_i      (in1[1]),
        .in2_i      (in2[1]),
        .gnt0_o     (gnt0[1]),
        .gnt1_o     (gnt1[1]),
        .sel_o      (sel[1]),
        .out_o      (dout_b),
        .out_valid_o(ov[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dut_vec(input int k);
        return {gnt0[k], gnt1[k], sel[k], ov[k], (k == 0) ? dout_a : dout_b};
    endfunction

    function automatic logic [7:0] exp_vec(input int k);
        return {m_owner[k] == 0, m_owner[k] == 1, m_owner[k] == 1, m_ov[k], m_out[k]};
    endfunction

    task automatic model_step(input int k);
        logic       rq [2];
        logic [3:0] d  [2];
        int         x;
        int         y;
        int         nxt;
        rq[0] = req0[k];
        rq[1] = req1[k];
        d[0]  = in1[k];
        d[1]  = in2[k];
        if (rst) begin
            m_owner[k] = -1;
            m_cnt[k]   = 0;
            m_last[k]  = 1;
            m_out[k]   = 4'h0;
            m_ov[k]    = 1'b0;
            return;
        end
        x   = m_owner[k];
        nxt = x;
        if (x >= 0 && rq[x]) begin
            m_out[k] = d[x];
            m_ov[k]  = 1'b1;
            if (m_cnt[k] < 15) m_cnt[k]++;
        end else begin
            m_ov[k] = 1'b0;
        end
        if (x < 0) begin
            if (rq[0] && rq[1]) nxt = 1 - m_last[k];
            else if (rq[0])     nxt = 0;
            else if (rq[1])     nxt = 1;
        end else begin
            y = 1 - x;
            if (!rq[x])                               nxt = rq[y] ? y : -1;
            else if (rq[y] && m_cnt[k] >= maxh[k])    nxt = y;
        end
        if (nxt != x) begin
            m_cnt[k] = 0;
            if (nxt >= 0) m_last[k] = nxt;
        end
        m_owner[k] = nxt;
    endtask

    // Advance both models on the current inputs, then clock and settle.
    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 2'b00;
        req1 = 2'b00;
        tick();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req0 = 2'b11;
        req1 = 2'b11;
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dut_vec(k) !== 8'h00) begin
                    bad++;
                    $display("FAIL reset inst%0d cyc%0d: got %b want 00000000", k, c, dut_vec(k));
                end
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if (gnt0[0] !== 1'b1 || gnt1[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_grant: gnt0=%b gnt1=%b want 1 0", gnt0[0], gnt1[0]);
        end
    endtask

    task automatic test_single();
        do_reset();
        req0[0] = 1'b1;
        req1[0] = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            in1[0] = 4'(i);
            tick();
            total++;
            if (gnt0[0] !== 1'b1 || ov[0] !== 1'b1 || dout_a !== 4'(i)) begin
                bad++;
                $display("FAIL single i=%0d: gnt0=%b ov=%b out=%h want 1 1 %h",
                         i, gnt0[0], ov[0], dout_a, 4'(i));
            end
        end
        req0[0] = 1'b0;
        tick();
        total++;
        if (gnt0[0] !== 1'b0 || ov[0] !== 1'b0 || dout_a !== 4'h9) begin
            bad++;
            $display("FAIL single_release: gnt0=%b ov=%b out=%h want 0 0 9", gnt0[0], ov[0], dout_a);
        end
    endtask

    task automatic test_contention();
        logic       g0_exp;
        logic [3:0] d_exp;
        do_reset();
        in1[0]  = 4'hA;
        in2[0]  = 4'h5;
        req0[0] = 1'b1;
        req1[0] = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            g0_exp = ((i / 4) % 2) == 0;
            d_exp  = g0_exp ? 4'hA : 4'h5;
            total++;
            if (gnt0[0] !== g0_exp || gnt1[0] !== !g0_exp || sel[0] !== !g0_exp) begin
                bad++;
                $display("FAIL contention_grant i=%0d: gnt0=%b gnt1=%b sel=%b want gnt0=%b",
                         i, gnt0[0], gnt1[0], sel[0], g0_exp);
            end
            tick();
            total++;
            if (ov[0] !== 1'b1 || dout_a !== d_exp) begin
                bad++;
                $display("FAIL contention_data i=%0d: ov=%b out=%h want 1 %h", i, ov[0], dout_a, d_exp);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req0[0] = 1'b0;
        req1[0] = 1'b1;
        tick();
        req0[0] = 1'b1;
        tick();
        tick();
        req1[0] = 1'b0;
        tick();
        total++;
        if (gnt0[0] !== 1'b1 || ov[0] !== 1'b0) begin
            bad++;
            $display("FAIL early_release_handover: gnt0=%b ov=%b want 1 0", gnt0[0], ov[0]);
        end
        req1[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (gnt0[0] !== 1'b1) begin
                bad++;
                $display("FAIL early_release_hold i=%0d: gnt0=%b want 1", i, gnt0[0]);
            end
            tick();
        end
        total++;
        if (gnt1[0] !== 1'b1) begin
            bad++;
            $display("FAIL early_release_rotate: gnt1=%b want 1", gnt1[0]);
        end
    endtask

    task automatic test_reset_mid();
        // Leaves instance 0 in a GNT1 tenure with both requests high.
        total++;
        if (gnt1[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre: gnt1=%b want 1", gnt1[0]);
        end
        rst = 1'b1;
        tick();
        total++;
        if (dut_vec(0) !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid: got %b want 00000000", dut_vec(0));
        end
        rst = 1'b0;
        tick();
        total++;
        if (gnt0[0] !== 1'b1 || gnt1[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_regrant: gnt0=%b gnt1=%b want 1 0", gnt0[0], gnt1[0]);
        end
    endtask

    task automatic test_max_hold1();
        logic prev_sel;
        do_reset();
        req0[1] = 1'b1;
        req1[1] = 1'b1;
        tick();
        prev_sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (gnt0[1] !== ((i % 2) == 0) || gnt1[1] !== ((i % 2) == 1) || sel[1] !== !prev_sel) begin
                bad++;
                $display("FAIL max_hold1 i=%0d: gnt0=%b gnt1=%b sel=%b want gnt0=%b",
                         i, gnt0[1], gnt1[1], sel[1], (i % 2) == 0);
            end
            prev_sel = sel[1];
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++) begin
                // A pending request stays up until its grant is visible.
                if (!req0[k] || m_owner[k] == 0) req0[k] = ($urandom_range(0, 3) != 0);
                if (!req1[k] || m_owner[k] == 1) req1[k] = ($urandom_range(0, 3) != 0);
                in1[k] = 4'($urandom);
                in2[k] = 4'($urandom);
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    bad++;
                    $display("FAIL random inst%0d cyc%0d: got %b want %b", k, c, dut_vec(k), exp_vec(k));
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        maxh[0] = 4;
        maxh[1] = 1;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_cnt[k]   = 0;
            m_last[k]  = 1;
            m_out[k]   = 4'h0;
            m_ov[k]    = 1'b0;
            in1[k]     = 4'h0;
            in2[k]     = 4'h0;
        end
        rst  = 1'b1;
        req0 = 2'b00;
        req1 = 2'b00;
        #2;
        test_reset();
        test_single();
        test_contention();
        test_early_release();
        test_reset_mid();
        test_max_hold1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
